// File: rtl/gen_2_2_arb.sv
// gen_2_2_arb: frame-granular round-robin arbiter sharing one gen_2_2 pooling-window generator
module gen_2_2_arb #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 22,
  parameter int reludata_num = 6,
  parameter int GAP = 4,
  parameter int DRAIN_MAX = 64
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  output logic [NUM_CH-1:0]          in_ready,
  input  logic                       gen_2_2_valid,
  output logic                       relu_valid,
  output logic [DATA_W-1:0]          relu_data,
  output logic [$clog2(NUM_CH)-1:0]  ch_sel,
  output logic                       busy,
  output logic                       frame_start,
  output logic                       frame_done,
  output logic                       err
);
  localparam int CW = $clog2(NUM_CH);
  localparam int NN = reludata_num * reludata_num;
  localparam int WIN = (reludata_num / 2) * (reludata_num / 2);
  localparam int PW = $clog2(NN + 1);
  localparam int WW = $clog2(WIN + 2);
  localparam int GW = $clog2(GAP + 1);
  localparam int DW = $clog2(DRAIN_MAX + 1);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t state, state_d;
  logic [CW-1:0] rr_ptr, rr_d, ch_d, gnt_hi, gnt_lo;
  logic hit_hi, xfer, rv_d, fs_d, fd_d, err_d;
  logic [PW-1:0] pix_cnt, pix_d;
  logic [WW-1:0] win_cnt, win_d;
  logic [GW-1:0] gap_cnt, gap_d;
  logic [DW-1:0] drn_cnt, drn_d;
  logic [DATA_W-1:0] sel_data, rd_d;
  // Prefer the lowest requester above the pointer, else wrap to the lowest overall
  always_comb begin
    hit_hi = 1'b0;
    gnt_hi = '0;
    gnt_lo = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (in_valid[i] && CW'(i) > rr_ptr) begin
        hit_hi = 1'b1;
        gnt_hi = CW'(i);
      end
      if (in_valid[i]) gnt_lo = CW'(i);
    end
  end
  assign sel_data = in_data[ch_sel*DATA_W +: DATA_W];
  assign in_ready = (state == STREAM && gap_cnt == '0) ? NUM_CH'(1) << ch_sel : '0;
  assign xfer = state == STREAM && gap_cnt == '0 && in_valid[ch_sel];
  assign busy = state != IDLE;
  always_comb begin
    state_d = state;
    ch_d = ch_sel;
    rr_d = rr_ptr;
    pix_d = pix_cnt;
    drn_d = drn_cnt;
    gap_d = (gap_cnt != '0) ? gap_cnt - 1'b1 : '0;
    rv_d = 1'b0;
    rd_d = '0;
    fs_d = 1'b0;
    fd_d = 1'b0;
    // Windows are counted before any drain-exit compare; overcount saturates at WIN+1
    win_d = (gen_2_2_valid && state != IDLE && win_cnt <= WW'(WIN)) ? win_cnt + 1'b1 : win_cnt;
    err_d = gen_2_2_valid && (state == IDLE || win_cnt >= WW'(WIN));
    case (state)
      IDLE: if (|in_valid) begin
        state_d = STREAM;
        ch_d = hit_hi ? gnt_hi : gnt_lo;
        fs_d = 1'b1;
        pix_d = '0;
        win_d = '0;
        gap_d = '0;
        drn_d = '0;
      end
      STREAM: if (xfer) begin
        rv_d = 1'b1;
        rd_d = sel_data;
        pix_d = pix_cnt + 1'b1;
        gap_d = GW'(GAP - 1);
        drn_d = '0;
        state_d = (pix_cnt == PW'(NN - 1)) ? DRAIN : STREAM;
      end
      DRAIN: if (win_d == WW'(WIN)) begin
        fd_d = 1'b1;
        rr_d = ch_sel;
        state_d = IDLE;
      end else if (drn_cnt == DW'(DRAIN_MAX - 1)) begin
        err_d = 1'b1;
        rr_d = ch_sel;
        state_d = IDLE;
      end else begin
        drn_d = drn_cnt + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      rr_ptr <= CW'(NUM_CH - 1);
      ch_sel <= '0;
      pix_cnt <= '0;
      win_cnt <= '0;
      gap_cnt <= '0;
      drn_cnt <= '0;
      relu_valid <= 1'b0;
      relu_data <= '0;
      frame_start <= 1'b0;
      frame_done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_d;
      rr_ptr <= rr_d;
      ch_sel <= ch_d;
      pix_cnt <= pix_d;
      win_cnt <= win_d;
      gap_cnt <= gap_d;
      drn_cnt <= drn_d;
      relu_valid <= rv_d;
      relu_data <= rd_d;
      frame_start <= fs_d;
      frame_done <= fd_d;
      err <= err_d;
    end
  end
endmodule

// File: tb/tb_gen_2_2_arb.sv
// tb_gen_2_2_arb: frame-level scoreboard, arbitration table, directed corner cases, random traffic
module tb_gen_2_2_arb;
  localparam int NUM_CH = 2, DATA_W = 22, N = 6, GAP = 4, DRAIN_MAX = 64;
  localparam int NN = N * N, WIN = (N / 2) * (N / 2);
  logic clk = 1'b0, rstn = 1'b0, gen_2_2_valid = 1'b0;
  logic [NUM_CH-1:0] in_valid = '0, in_ready;
  logic [NUM_CH*DATA_W-1:0] in_data = '0;
  logic relu_valid, busy, frame_start, frame_done, err;
  logic [DATA_W-1:0] relu_data;
  logic [0:0] ch_sel;
  gen_2_2_arb #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .reludata_num(N), .GAP(GAP), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .gen_2_2_valid(gen_2_2_valid), .relu_valid(relu_valid), .relu_data(relu_data), .ch_sel(ch_sel),
    .busy(busy), .frame_start(frame_start), .frame_done(frame_done), .err(err));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc_n = 0;
  // reference model: frame-level bookkeeping
  bit m_act;
  int m_ch, m_rr, m_pix, m_win, m_drain, m_since;
  // gen_2_2 stub, driver and trace state
  int st_pix, st_wins, st_max = WIN;
  logic [NUM_CH-1:0] want = '0;
  logic [DATA_W-1:0] cur [NUM_CH];
  int rv_cnt, rv_last, gap_bad, err_cnt, err_cyc, done_cnt, last_grant, n;
  typedef struct { logic [NUM_CH-1:0] pat; int ch; } vec_t;
  vec_t tbl [9];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask
  task automatic model_reset();
    m_act = 0; m_ch = 0; m_rr = NUM_CH - 1; m_pix = 0; m_win = 0; m_drain = 0; m_since = 0;
    st_pix = 0; st_wins = 0;
  endtask
  task automatic cyc();
    logic [NUM_CH-1:0] pv, pr;
    logic [NUM_CH*DATA_W-1:0] pd;
    logic pg, ers, efs, efd, eerr;
    logic [DATA_W-1:0] edat;
    int g, pvi, erdy;
    in_valid = want;
    for (int c = 0; c < NUM_CH; c++) in_data[c*DATA_W +: DATA_W] = cur[c];
    pv = in_valid; pr = in_ready; pd = in_data; pg = gen_2_2_valid;
    @(posedge clk);
    #1;
    cyc_n++;
    if (!rstn) begin
      chk("reset_outputs", 64'({in_ready, relu_valid, relu_data, ch_sel, busy, frame_start, frame_done, err}), 64'(0));
      model_reset();
      gen_2_2_valid = 1'b0;
      return;
    end
    for (int c = 0; c < NUM_CH; c++) if (pv[c] && pr[c]) cur[c] = DATA_W'($urandom);
    ers = 0; efs = 0; efd = 0; eerr = 0; edat = '0; g = 0; pvi = int'(pv);
    if (m_act) begin
      if (pg) begin
        m_win++;
        if (m_win > WIN) eerr = 1;
      end
      if (m_pix == NN) begin
        if (m_win == WIN) begin
          efd = 1; m_act = 0; m_rr = m_ch;
        end else begin
          m_drain++;
          if (m_drain == DRAIN_MAX) begin
            eerr = 1; m_act = 0; m_rr = m_ch;
          end
        end
      end else if (pv[m_ch] && m_since >= GAP - 1) begin
        ers = 1; edat = pd[m_ch*DATA_W +: DATA_W]; m_pix++; m_since = 0; m_drain = 0;
      end else begin
        m_since++;
      end
    end else begin
      if (pg) eerr = 1;
      if (pvi != 0) begin
        for (int d = NUM_CH; d >= 1; d--) if (((pvi >> ((m_rr + d) % NUM_CH)) & 1) == 1) g = (m_rr + d) % NUM_CH;
        m_act = 1; m_ch = g; m_pix = 0; m_win = 0; m_drain = 0; m_since = GAP; efs = 1;
      end
    end
    erdy = (m_act && m_pix < NN && m_since >= GAP - 1) ? (1 << m_ch) : 0;
    chk("relu_valid", 64'(relu_valid), 64'(ers));
    chk("relu_data", 64'(relu_data), 64'(edat));
    chk("frame_start", 64'(frame_start), 64'(efs));
    chk("frame_done", 64'(frame_done), 64'(efd));
    chk("err", 64'(err), 64'(eerr));
    chk("busy", 64'(busy), 64'(m_act));
    chk("ch_sel", 64'(ch_sel), 64'(m_ch));
    chk("in_ready", 64'(in_ready), 64'(erdy));
    if (frame_start) begin
      rv_cnt = 0; gap_bad = 0; last_grant = int'(ch_sel); st_pix = 0; st_wins = 0;
    end
    if (relu_valid) begin
      if (rv_cnt > 0 && cyc_n - rv_last != GAP) gap_bad++;
      rv_last = cyc_n;
      rv_cnt++;
    end
    if (err) begin
      err_cnt++; err_cyc = cyc_n;
    end
    if (frame_done) done_cnt++;
    // stub: one window per pixel at odd row and odd column of the frame
    gen_2_2_valid = 1'b0;
    if (relu_valid) begin
      if ((st_pix / N) % 2 == 1 && (st_pix % N) % 2 == 1 && st_wins < st_max) begin
        gen_2_2_valid = 1'b1; st_wins++;
      end
      st_pix++;
    end
  endtask
  task automatic run_frame(input int lim);
    n = 0;
    do begin
      cyc(); n++;
    end while (!frame_done && !err && n < lim);
    chk("frame_end_bound", 64'(n < lim), 64'(1));
  endtask
  task automatic run_pix(input int k);
    n = 0;
    do begin
      cyc(); n++;
    end while (rv_cnt < k && n < 400);
    chk("pixel_bound", 64'(rv_cnt), 64'(k));
  endtask
  initial begin
    int d0, e0;
    tbl[0] = '{2'b11, 1}; tbl[1] = '{2'b11, 0}; tbl[2] = '{2'b11, 1};
    tbl[3] = '{2'b10, 1}; tbl[4] = '{2'b10, 1}; tbl[5] = '{2'b01, 0};
    tbl[6] = '{2'b01, 0}; tbl[7] = '{2'b11, 1}; tbl[8] = '{2'b11, 0};
    for (int c = 0; c < NUM_CH; c++) cur[c] = DATA_W'($urandom);
    rv_cnt = 0; rv_last = 0; gap_bad = 0; err_cnt = 0; err_cyc = 0; done_cnt = 0; last_grant = -1;
    model_reset();
    want = 2'b11;
    rstn = 1'b0;
    repeat (2) cyc();
    rstn = 1'b1;
    cyc();
    chk("t1_first_grant", 64'(last_grant), 64'(0));
    want = 2'b01;
    d0 = done_cnt;
    run_frame(400);
    chk("t2_pixels", 64'(rv_cnt), 64'(NN));
    chk("t2_spacing", 64'(gap_bad), 64'(0));
    chk("t2_done", 64'(done_cnt - d0), 64'(1));
    want = 2'b00;
    cyc();
    chk("t2_busy_after", 64'(busy), 64'(0));
    foreach (tbl[i]) begin
      want = tbl[i].pat;
      run_frame(400);
      chk("t3_tbl_grant", 64'(last_grant), 64'(tbl[i].ch));
      chk("t3_tbl_pixels", 64'(rv_cnt), 64'(NN));
    end
    want = 2'b10;
    rv_cnt = 0;
    run_pix(10);
    chk("t4_grant", 64'(last_grant), 64'(1));
    want = 2'b00;
    d0 = rv_cnt;
    repeat (20) cyc();
    chk("t4_pause_fwd", 64'(rv_cnt - d0), 64'(0));
    chk("t4_pause_busy", 64'({busy, ch_sel}), 64'(2'b11));
    want = 2'b10;
    run_frame(400);
    chk("t4_pixels", 64'(rv_cnt), 64'(NN));
    st_max = WIN - 1;
    want = 2'b11;
    d0 = done_cnt; e0 = err_cnt;
    run_frame(400);
    chk("t5_err", 64'(err_cnt - e0), 64'(1));
    chk("t5_no_done", 64'(done_cnt - d0), 64'(0));
    chk("t5_timeout_lat", 64'(err_cyc - rv_last), 64'(DRAIN_MAX));
    st_max = WIN;
    run_frame(400);
    chk("t5_next_grant", 64'(last_grant), 64'(1));
    want = 2'b00;
    cyc();
    e0 = err_cnt;
    gen_2_2_valid = 1'b1;
    cyc();
    chk("t6_stray_err", 64'(err_cnt - e0), 64'(1));
    want = 2'b01;
    run_pix(20);
    #2 rstn = 1'b0;
    #1 chk("t6_async_reset", 64'({in_ready, relu_valid, relu_data, busy, frame_start, frame_done, err}), 64'(0));
    repeat (2) cyc();
    rstn = 1'b1;
    d0 = done_cnt;
    run_frame(400);
    chk("t6_restart_grant", 64'(last_grant), 64'(0));
    chk("t6_restart_pixels", 64'(rv_cnt), 64'(NN));
    chk("t6_restart_done", 64'(done_cnt - d0), 64'(1));
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) want = NUM_CH'($urandom);
      cyc();
    end
    want = '1;
    if (busy) run_frame(600);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
